// File: rtl/cascaded_counter_cmp_if.sv
// Control/status bundle for cascaded_counter_cmp: count/load controls in,
// counter value, carry chain and compare flags out.
interface cascaded_counter_cmp_if #(
  parameter int STAGE_W = 4,
  parameter int NSTAGES = 4
);
  localparam int WIDTH = STAGE_W * NSTAGES;

  logic               P_0;
  logic               DIR;
  logic               LOAD;
  logic [WIDTH-1:0]   LD_VAL;
  logic [WIDTH-1:0]   CMP;
  logic [WIDTH-1:0]   MASK;
  logic               CLR;
  logic [WIDTH-1:0]   Q;
  logic [NSTAGES-1:0] CARRY;
  logic               TC;
  logic               Z;
  logic               Z_STICKY;

  modport master (
    output P_0, DIR, LOAD, LD_VAL, CMP, MASK, CLR,
    input  Q, CARRY, TC, Z, Z_STICKY
  );

  modport slave (
    input  P_0, DIR, LOAD, LD_VAL, CMP, MASK, CLR,
    output Q, CARRY, TC, Z, Z_STICKY
  );
endinterface

// File: rtl/cascaded_counter_cmp.sv
// Up/down counter built from NSTAGES ripple-enabled stages, with optional
// saturation, registered masked compare and a sticky match flag.
module cascaded_counter_cmp #(
  parameter int STAGE_W  = 4,
  parameter int NSTAGES  = 4,
  parameter int SATURATE = 0
) (
  input logic                   CK,
  input logic                   RST_N,
  cascaded_counter_cmp_if.slave bus
);
  localparam int WIDTH = STAGE_W * NSTAGES;

  logic [NSTAGES-1:0][STAGE_W-1:0] q, q_nxt;
  logic [NSTAGES-1:0]              stg_term;
  logic [NSTAGES-1:0]              carry;
  logic                            tc, hold, match;
  logic                            z, z_sticky;

  // A stage steps only when every lower stage sits at its terminal digit,
  // which reproduces full-width +/-1 without a wide adder.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    assign stg_term[k] = bus.DIR ? (q[k] == '0) : (q[k] == '1);

    if (k == 0) begin : g_c0
      assign carry[k] = bus.P_0;
    end else begin : g_ck
      assign carry[k] = carry[k-1] & stg_term[k-1];
    end

    assign q_nxt[k] = bus.LOAD          ? bus.LD_VAL[k*STAGE_W +: STAGE_W] :
                      (carry[k] && !hold) ? (bus.DIR ? q[k] - STAGE_W'(1)
                                                     : q[k] + STAGE_W'(1)) :
                      q[k];
  end

  assign tc    = carry[NSTAGES-1] & stg_term[NSTAGES-1];
  assign hold  = (SATURATE != 0) && tc;
  assign match = (((q ^ bus.CMP) & bus.MASK) == '0);

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      q        <= '0;
      z        <= 1'b0;
      z_sticky <= 1'b0;
    end else begin
      q        <= q_nxt;
      z        <= match;
      z_sticky <= match | (z_sticky & ~bus.CLR);
    end
  end

  assign bus.Q        = WIDTH'(q);
  assign bus.CARRY    = carry;
  assign bus.TC       = tc;
  assign bus.Z        = z;
  assign bus.Z_STICKY = z_sticky;
endmodule
